// File: rtl/demux_rr_dispatch.sv
// Round-robin dispatcher feeding a 1-to-4 demux: accepts one bit per cycle,
// picks the next ready lane from a rotating (or locked) pointer, registers data/select.
module demux_rr_dispatch #(
    parameter logic [1:0] START_LANE = 2'd0,
    parameter int         CNT_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic             in_data_i,
    output logic             in_ready_o,
    input  logic [3:0]       lane_rdy_i,
    input  logic             lock_i,
    output logic             dout_o,
    output logic             dout_valid_o,
    output logic             sel1_o,
    output logic             sel0_o,
    output logic [CNT_W-1:0] disp_cnt_o
);

    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       grant;
    logic [1:0]       lane;
    logic             found;
    logic             accept;

    // First ready lane at or after the pointer, wrapping mod 4.
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        grant = ptr_q;
        lane  = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lane = ptr_q + 2'(i);
            if (!found && lane_rdy_i[lane]) begin
                grant = lane;
                found = 1'b1;
            end
        end
    end

    assign in_ready_o = rst_ni & (|lane_rdy_i);
    assign accept     = in_valid_i & in_ready_o;

    // Select and data keep their stale values between accepts; the demux
    // consumer qualifies them with dout_valid.
    always_comb begin
        ptr_d        = ptr_q;
        sel_d        = sel_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        cnt_d        = cnt_q;
        if (accept) begin
            dout_d       = in_data_i;
            sel_d        = grant;
            dout_valid_d = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
            ptr_d        = lock_i ? grant : grant + 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q        <= START_LANE;
            sel_q        <= 2'd0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            ptr_q        <= ptr_d;
            sel_q        <= sel_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign sel1_o       = sel_q[1];
    assign sel0_o       = sel_q[0];
    assign disp_cnt_o   = cnt_q;

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Directed self-checking bench for demux_rr_dispatch; two instances share the
// stimulus, one with START_LANE=0 and one with START_LANE=2.
module tb_demux_rr_dispatch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_data;
    logic [3:0] lane_rdy;
    logic       lock;

    logic       d0_ready, d0_dout, d0_valid, d0_sel1, d0_sel0;
    logic [7:0] d0_cnt;
    logic       d2_ready, d2_dout, d2_valid, d2_sel1, d2_sel0;
    logic [7:0] d2_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    demux_rr_dispatch #(.START_LANE(2'd0), .CNT_W(8)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(d0_ready), .lane_rdy_i(lane_rdy), .lock_i(lock),
        .dout_o(d0_dout), .dout_valid_o(d0_valid), .sel1_o(d0_sel1), .sel0_o(d0_sel0),
        .disp_cnt_o(d0_cnt)
    );

    demux_rr_dispatch #(.START_LANE(2'd2), .CNT_W(8)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(d2_ready), .lane_rdy_i(lane_rdy), .lock_i(lock),
        .dout_o(d2_dout), .dout_valid_o(d2_valid), .sel1_o(d2_sel1), .sel0_o(d2_sel0),
        .disp_cnt_o(d2_cnt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] rot_data = 5'b01101;  // bit i is the i-th data bit: 1,0,1,1,0
    logic [3:0] gap_valid = 4'b1001;  // bit i is in_valid on cycle i: 1,0,0,1

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_data = 1'b1; lane_rdy = 4'hf; lock = 1'b0;
        #1;
        check("ready_in_reset", 16'(d0_ready), 16'd0);
        tick();
        check("rst_dout",  16'(d0_dout),  16'd0);
        check("rst_valid", 16'(d0_valid), 16'd0);
        check("rst_sel",   16'({d0_sel1, d0_sel0}), 16'd0);
        check("rst_cnt",   16'(d0_cnt),   16'd0);

        // Rotation over all-ready lanes.
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = rot_data[i];
            tick();
            check("rot_dout",  16'(d0_dout),  16'(rot_data[i]));
            check("rot_sel",   16'({d0_sel1, d0_sel0}), 16'(i % 4));
            check("rot_valid", 16'(d0_valid), 16'd1);
        end
        check("rot_cnt", 16'(d0_cnt), 16'd5);
        in_valid = 1'b0;
        tick();
        check("rot_idle_valid", 16'(d0_valid), 16'd0);

        // Pointer is 1; only lane 3 ready.
        lane_rdy = 4'b1000; in_valid = 1'b1; in_data = 1'b1;
        tick();
        check("skip_sel",   16'({d0_sel1, d0_sel0}), 16'd3);
        check("skip_valid", 16'(d0_valid), 16'd1);
        lane_rdy = 4'b0000;
        #1;
        check("none_ready", 16'(d0_ready), 16'd0);
        tick();
        check("none_valid", 16'(d0_valid), 16'd0);
        check("none_sel",   16'({d0_sel1, d0_sel0}), 16'd3);
        check("none_cnt",   16'(d0_cnt), 16'd6);

        // Pointer should still be 0: two rotating accepts give lanes 0,1.
        lane_rdy = 4'hf;
        tick();
        check("ptr_hold_sel0", 16'({d0_sel1, d0_sel0}), 16'd0);
        tick();
        check("ptr_hold_sel1", 16'({d0_sel1, d0_sel0}), 16'd1);

        // Locked burst on lane 2.
        lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = i[0];
            tick();
            check("lock_sel",  16'({d0_sel1, d0_sel0}), 16'd2);
            check("lock_dout", 16'(d0_dout), 16'(i[0]));
        end
        lane_rdy = 4'b1011;
        tick();
        check("lock_move_sel", 16'({d0_sel1, d0_sel0}), 16'd3);
        lane_rdy = 4'hf;
        tick();
        check("lock_new_sel", 16'({d0_sel1, d0_sel0}), 16'd3);
        check("lock_cnt", 16'(d0_cnt), 16'd14);

        // Idle gaps from a fresh reset.
        lock = 1'b0; rst_n = 1'b0; in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = gap_valid[i];
            tick();
            check("gap_valid", 16'(d0_valid), 16'(gap_valid[i]));
            check("gap_sel",   16'({d0_sel1, d0_sel0}), (i < 3) ? 16'd0 : 16'd1);
        end
        check("gap_cnt", 16'(d0_cnt), 16'd2);

        // Counter wrap.
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        check("wrap_255", 16'(d0_cnt), 16'd255);
        tick();
        check("wrap_256", 16'(d0_cnt), 16'd0);
        check("wrap_valid_cont", 16'(d0_valid), 16'd1);
        tick();
        check("wrap_257", 16'(d0_cnt), 16'd1);

        // Reset mid-stream on the START_LANE=2 instance.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_data = 1'b1;
        tick();
        check("s2_first_sel", 16'({d2_sel1, d2_sel0}), 16'd2);
        tick();
        check("s2_second_sel", 16'({d2_sel1, d2_sel0}), 16'd3);
        rst_n = 1'b0;
        #1;
        check("s2_ready_in_reset", 16'(d2_ready), 16'd0);
        tick();
        check("s2_rst_valid", 16'(d2_valid), 16'd0);
        check("s2_rst_sel",   16'({d2_sel1, d2_sel0}), 16'd0);
        check("s2_rst_cnt",   16'(d2_cnt), 16'd0);
        check("s2_rst_dout",  16'(d2_dout), 16'd0);
        rst_n = 1'b1;
        tick();
        check("s2_post_sel",   16'({d2_sel1, d2_sel0}), 16'd2);
        check("s2_post_valid", 16'(d2_valid), 16'd1);
        check("s2_post_dout",  16'(d2_dout), 16'd1);
        check("s2_post_cnt",   16'(d2_cnt), 16'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
